// File: rtl/tree_path_tracker.sv
// Identifier-path stack with dependency-table lookup over a valid/ready result channel.
// Define TREE_PATH_PARALLEL_EN to compare all table entries in a single search cycle.
module tree_path_tracker #(
    parameter int NUM_MSG_HIERARCHY = 2,
    parameter int NUM_MSGS          = 2,
    parameter int IDENTIFIER_SIZE   = 5,
    parameter int NODE_DATA_W       = 1,
    localparam int IW = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
    localparam int DW = $clog2(NUM_MSG_HIERARCHY + 1)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              evt_valid,
    output logic                                              evt_ready,
    input  logic                                              evt_push,
    input  logic [IDENTIFIER_SIZE-1:0]                        evt_id,
    input  logic [NUM_MSGS*NUM_MSG_HIERARCHY*IDENTIFIER_SIZE-1:0] dep_table,
    input  logic [NUM_MSGS*NODE_DATA_W-1:0]                   node_table,
    output logic                                              res_valid,
    input  logic                                              res_ready,
    output logic                                              res_hit,
    output logic [IW-1:0]                                     res_index,
    output logic [NODE_DATA_W-1:0]                            res_node,
    output logic [DW-1:0]                                     depth,
    output logic [2:0]                                        err
);
    localparam int PW = NUM_MSG_HIERARCHY * IDENTIFIER_SIZE;

    typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

    state_t                     state;
    logic [IDENTIFIER_SIZE-1:0] stack [NUM_MSG_HIERARCHY];
    logic [PW-1:0]              path;
    logic [NUM_MSGS-1:0]        match;
    logic                       found;
    logic [IW-1:0]              found_idx;
    logic [NODE_DATA_W-1:0]     found_node;
    logic                       last;

    assign evt_ready = (state == IDLE);
    assign res_valid = (state == RESP);

    // Levels at or above depth are kept zero, so the stack is the path.
    always_comb begin
        path = '0;
        for (int l = 0; l < NUM_MSG_HIERARCHY; l++)
            path[l*IDENTIFIER_SIZE +: IDENTIFIER_SIZE] = stack[l];
    end

    always_comb begin
        match = '0;
        for (int e = 0; e < NUM_MSGS; e++)
            match[e] = (dep_table[e*PW +: PW] == path);
    end

`ifdef TREE_PATH_PARALLEL_EN
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int e = NUM_MSGS - 1; e >= 0; e--) begin
            if (match[e]) begin
                found     = 1'b1;
                found_idx = IW'(e);
            end
        end
    end

    assign last = 1'b1;
`else
    logic [IW-1:0] idx;

    assign found     = match[idx];
    assign found_idx = idx;
    assign last      = (idx == IW'(NUM_MSGS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx <= '0;
        else if (state != SEARCH)
            idx <= '0;
        else if (!found && !last)
            idx <= idx + 1'b1;
    end
`endif

    always_comb begin
        found_node = '0;
        for (int e = 0; e < NUM_MSGS; e++)
            if (IW'(e) == found_idx)
                found_node = node_table[e*NODE_DATA_W +: NODE_DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            res_hit   <= 1'b0;
            res_index <= '0;
            res_node  <= '0;
            depth     <= '0;
            err       <= '0;
            for (int l = 0; l < NUM_MSG_HIERARCHY; l++)
                stack[l] <= '0;
        end else begin
            err <= '0;
            unique case (state)
                IDLE: begin
                    if (evt_valid) begin
                        if (evt_push) begin
                            if (depth == DW'(NUM_MSG_HIERARCHY)) begin
                                err[0] <= 1'b1;
                            end else if (evt_id == '0) begin
                                err[2] <= 1'b1;
                            end else begin
                                for (int l = 0; l < NUM_MSG_HIERARCHY; l++)
                                    if (DW'(l) == depth)
                                        stack[l] <= evt_id;
                                depth <= depth + 1'b1;
                                state <= SEARCH;
                            end
                        end else if (depth == '0) begin
                            err[1] <= 1'b1;
                        end else begin
                            for (int l = 0; l < NUM_MSG_HIERARCHY; l++)
                                if (DW'(l) == depth - 1'b1)
                                    stack[l] <= '0;
                            depth <= depth - 1'b1;
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (found) begin
                        res_hit   <= 1'b1;
                        res_index <= found_idx;
                        res_node  <= found_node;
                        state     <= RESP;
                    end else if (last) begin
                        res_hit   <= 1'b0;
                        res_index <= '0;
                        res_node  <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
